// File: rtl/d_phy_slave_adapter_layer.sv
// D-PHY receive PHY adapter: deskews N lane byte streams into
// lane-aligned words with burst framing and error flags.
module d_phy_slave_adapter_layer #(
  parameter int N_DATA_LANES = 4,
  parameter int SKEW_DEPTH   = 4,
  parameter int MAX_SKEW     = 3
) (
  input  logic                      hs_rx_word_clk,
  input  logic                      rst,
  input  logic [N_DATA_LANES-1:0]   rx_active_hs,
  input  logic [N_DATA_LANES-1:0]   rx_sync_hs,
  input  logic [N_DATA_LANES-1:0]   rx_valid_hs,
  input  logic [N_DATA_LANES*8-1:0] rx_data_hs,
  input  logic [N_DATA_LANES-1:0]   stop_state,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_DATA_LANES*8-1:0] out_data,
  output logic                      out_sos,
  output logic                      out_eos,
  output logic                      all_stop,
  output logic                      err_skew,
  output logic                      err_len,
  output logic                      err_overflow,
  output logic [15:0]               burst_words
);

  localparam int N  = N_DATA_LANES;
  localparam int W  = 8 * N;
  localparam int AW = $clog2(SKEW_DEPTH);
  localparam int CW = $clog2(MAX_SKEW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_STREAM, S_FLUSH, S_DROP
  } state_t;

  typedef logic [AW:0] ptr_t;

  state_t          state_q, state_d;
  logic [N-1:0]    synced_q, synced_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  ptr_t            wp_q [N];
  ptr_t            rp_q [N];
  logic [7:0]      mem_q [N][SKEW_DEPTH];
  logic [W-1:0]    la_q, la_d, hd_q, hd_d;
  logic            la_v_q, la_v_d, la_sos_q, la_sos_d;
  logic            hd_v_q, hd_v_d, hd_sos_q, hd_sos_d;
  logic            hd_eos_q, hd_eos_d;
  logic            sos_pend_q, sos_pend_d;
  logic [15:0]     wcnt_q, wcnt_d, bw_q, bw_d;
  logic            e_skew_q, e_len_q, e_ovf_q;
  logic            e_skew, e_len, e_ovf;
  logic            stop_q;

  logic [N-1:0]    empty, full, push, wr;
  logic [W-1:0]    head;
  logic            in_rx, all_ne, any_ne, act_any;
  logic            hd_free, pop, ovf, clr;

  always_comb begin
    empty = '0;
    full  = '0;
    push  = '0;
    wr    = '0;
    head  = '0;
    in_rx = (state_q == S_ALIGN) || (state_q == S_STREAM);
    for (int i = 0; i < N; i++) begin
      empty[i] = wp_q[i] == rp_q[i];
      full[i]  = (wp_q[i][AW] != rp_q[i][AW]) &&
                 (wp_q[i][AW-1:0] == rp_q[i][AW-1:0]);
      push[i]  = in_rx && synced_q[i] && rx_valid_hs[i];
      head[8*i +: 8] = mem_q[i][rp_q[i][AW-1:0]];
    end
    all_ne  = &(~empty);
    any_ne  = |(~empty);
    act_any = |rx_active_hs;
    hd_free = !hd_v_q || out_ready;
    pop     = (state_q == S_STREAM) && all_ne && (!la_v_q || hd_free);
    // a full lane still accepts a byte when the word pop frees a slot
    ovf     = |(push & full & {N{~pop}});
    wr      = push & (~full | {N{pop}});
  end

  always_comb begin
    state_d    = state_q;
    synced_d   = synced_q;
    cnt_d      = cnt_q;
    clr        = 1'b0;
    e_skew     = 1'b0;
    e_len      = 1'b0;
    e_ovf      = 1'b0;
    la_d       = la_q;
    la_v_d     = la_v_q;
    la_sos_d   = la_sos_q;
    hd_d       = hd_q;
    hd_v_d     = hd_v_q;
    hd_sos_d   = hd_sos_q;
    hd_eos_d   = hd_eos_q;
    sos_pend_d = sos_pend_q;
    wcnt_d     = wcnt_q;
    bw_d       = bw_q;
    if (hd_v_q && out_ready) begin
      hd_v_d = 1'b0;
      wcnt_d = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
    end
    if (pop) begin
      if (la_v_q) begin
        hd_d     = la_q;
        hd_v_d   = 1'b1;
        hd_sos_d = la_sos_q;
        hd_eos_d = 1'b0;
      end
      la_d       = head;
      la_v_d     = 1'b1;
      la_sos_d   = sos_pend_q;
      sos_pend_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        clr        = 1'b1;
        wcnt_d     = '0;
        sos_pend_d = 1'b1;
        synced_d   = '0;
        cnt_d      = '0;
        if (|rx_sync_hs) begin
          synced_d = rx_sync_hs;
          state_d  = (&rx_sync_hs) ? S_STREAM : S_ALIGN;
        end
      end
      S_ALIGN: begin
        synced_d = synced_q | rx_sync_hs;
        cnt_d    = cnt_q + CW'(1);
        if (ovf) begin
          e_ovf   = 1'b1;
          state_d = S_DROP;
        end else if (&synced_d) begin
          state_d = S_STREAM;
        end else if (cnt_d == CW'(MAX_SKEW)) begin
          e_skew  = 1'b1;
          state_d = S_DROP;
        end
      end
      S_STREAM: begin
        if (ovf) begin
          e_ovf   = 1'b1;
          state_d = S_DROP;
        end else if (!act_any && !any_ne) begin
          state_d = S_FLUSH;
        end else if (!act_any && !all_ne) begin
          e_len   = 1'b1;
          clr     = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (la_v_q && hd_free) begin
          hd_d     = la_q;
          hd_v_d   = 1'b1;
          hd_sos_d = la_sos_q;
          hd_eos_d = 1'b1;
          la_v_d   = 1'b0;
        end else if (!la_v_q && hd_v_q && hd_eos_q && out_ready) begin
          bw_d    = wcnt_d;
          state_d = S_IDLE;
        end else if (!la_v_q && !hd_v_q) begin
          bw_d    = wcnt_q;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (!act_any) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DROP) begin
      clr      = 1'b1;
      la_v_d   = 1'b0;
      hd_v_d   = 1'b0;
      hd_sos_d = 1'b0;
      hd_eos_d = 1'b0;
    end
  end

  always_ff @(posedge hs_rx_word_clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr) begin
          wp_q[i] <= '0;
          rp_q[i] <= '0;
        end else begin
          if (wr[i]) wp_q[i] <= wp_q[i] + ptr_t'(1);
          if (pop)   rp_q[i] <= rp_q[i] + ptr_t'(1);
        end
      end
    end
  end

  always_ff @(posedge hs_rx_word_clk) begin
    for (int i = 0; i < N; i++)
      if (wr[i]) mem_q[i][wp_q[i][AW-1:0]] <= rx_data_hs[8*i +: 8];
  end

  always_ff @(posedge hs_rx_word_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      synced_q   <= '0;
      cnt_q      <= '0;
      la_q       <= '0;
      la_v_q     <= 1'b0;
      la_sos_q   <= 1'b0;
      hd_q       <= '0;
      hd_v_q     <= 1'b0;
      hd_sos_q   <= 1'b0;
      hd_eos_q   <= 1'b0;
      sos_pend_q <= 1'b0;
      wcnt_q     <= '0;
      bw_q       <= '0;
      e_skew_q   <= 1'b0;
      e_len_q    <= 1'b0;
      e_ovf_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      synced_q   <= synced_d;
      cnt_q      <= cnt_d;
      la_q       <= la_d;
      la_v_q     <= la_v_d;
      la_sos_q   <= la_sos_d;
      hd_q       <= hd_d;
      hd_v_q     <= hd_v_d;
      hd_sos_q   <= hd_sos_d;
      hd_eos_q   <= hd_eos_d;
      sos_pend_q <= sos_pend_d;
      wcnt_q     <= wcnt_d;
      bw_q       <= bw_d;
      e_skew_q   <= e_skew;
      e_len_q    <= e_len;
      e_ovf_q    <= e_ovf;
      stop_q     <= &stop_state;
    end
  end

  assign out_valid    = hd_v_q;
  assign out_data     = hd_q;
  assign out_sos      = hd_sos_q;
  assign out_eos      = hd_eos_q;
  assign all_stop     = stop_q;
  assign err_skew     = e_skew_q;
  assign err_len      = e_len_q;
  assign err_overflow = e_ovf_q;
  assign burst_words  = bw_q;

endmodule

// File: tb/tb_d_phy_slave_adapter_layer.sv
// Bench for the D-PHY receive adapter: burst vector table
// plus hand sequences for reset and stop-state handling.
module tb_d_phy_slave_adapter_layer;

  logic        clk;
  logic        rst;
  logic [3:0]  rx_active_hs;
  logic [3:0]  rx_sync_hs;
  logic [3:0]  rx_valid_hs;
  logic [31:0] rx_data_hs;
  logic [3:0]  stop_state;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sos;
  logic        out_eos;
  logic        all_stop;
  logic        err_skew;
  logic        err_len;
  logic        err_overflow;
  logic [15:0] burst_words;

  d_phy_slave_adapter_layer #(
    .N_DATA_LANES(4), .SKEW_DEPTH(4), .MAX_SKEW(3)
  ) dut (
    .hs_rx_word_clk(clk),
    .rst(rst),
    .rx_active_hs(rx_active_hs),
    .rx_sync_hs(rx_sync_hs),
    .rx_valid_hs(rx_valid_hs),
    .rx_data_hs(rx_data_hs),
    .stop_state(stop_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sos(out_sos),
    .out_eos(out_eos),
    .all_stop(all_stop),
    .err_skew(err_skew),
    .err_len(err_len),
    .err_overflow(err_overflow),
    .burst_words(burst_words)
  );

  typedef struct packed {
    logic [3:0][7:0]   dly;
    logic [3:0][7:0]   nb;
    logic [7:0]        rlo_at;
    logic [7:0]        rlo_len;
    logic [7:0]        exp_words;
    logic              exp_skew;
    logic              exp_len;
    logic              exp_ovf;
    logic [15:0]       exp_bw;
    logic signed [7:0] exp_lat;
  } vec_t;

  vec_t tbl [8];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start = 0;
  int lat = -1;
  int n_skew = 0;
  int n_len = 0;
  int n_ovf = 0;
  logic [31:0] wq [$];
  bit          sq [$];
  bit          eq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid && lat < 0) lat = cyc - start;
    if (out_valid && out_ready) begin
      wq.push_back(out_data);
      sq.push_back(out_sos);
      eq.push_back(out_eos);
    end
    if (err_skew)     n_skew++;
    if (err_len)      n_len++;
    if (err_overflow) n_ovf++;
  end

  task automatic chk(input string nm, input int idx,
                     input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, got, exp);
    end
  endtask

  task automatic drive_cycle(input vec_t v, input int c);
    for (int i = 0; i < 4; i++) begin
      int d;
      int n;
      d = int'(v.dly[i]);
      n = int'(v.nb[i]);
      rx_active_hs[i] = c < d + n + 1;
      rx_sync_hs[i]   = c == d;
      rx_valid_hs[i]  = c > d && c <= d + n;
      rx_data_hs[8*i +: 8] = rx_valid_hs[i] ? 8'(4 * (c - d - 1) + i) : 8'h00;
      stop_state[i]   = ~rx_active_hs[i];
    end
    out_ready = !(c >= int'(v.rlo_at) &&
                  c < int'(v.rlo_at) + int'(v.rlo_len));
  endtask

  task automatic clear_mon();
    wq.delete();
    sq.delete();
    eq.delete();
    n_skew = 0;
    n_len  = 0;
    n_ovf  = 0;
    lat    = -1;
    start  = cyc;
  endtask

  task automatic run_burst(input int id, input vec_t v);
    int mx;
    int n;
    int ew;
    logic [31:0] e;
    mx = 0;
    for (int i = 0; i < 4; i++)
      if (int'(v.dly[i]) + int'(v.nb[i]) > mx)
        mx = int'(v.dly[i]) + int'(v.nb[i]);
    for (int c = 0; c <= mx + 21; c++) begin
      @(posedge clk); #1;
      if (c == 0) clear_mon();
      drive_cycle(v, c);
    end
    @(negedge clk);
    n  = wq.size();
    ew = int'(v.exp_words);
    chk("words", id, n, ew);
    for (int k = 0; k < n && k < ew; k++) begin
      for (int i = 0; i < 4; i++) e[8*i +: 8] = 8'(4 * k + i);
      chk("data", id * 100 + k, wq[k], e);
      chk("sos", id * 100 + k, sq[k], k == 0);
      chk("eos", id * 100 + k, eq[k], k == ew - 1);
    end
    chk("err_skew", id, n_skew, v.exp_skew);
    chk("err_len", id, n_len, v.exp_len);
    chk("err_ovf", id, n_ovf, v.exp_ovf);
    chk("burst_words", id, burst_words, v.exp_bw);
    chk("latency", id, lat, int'(v.exp_lat));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{dly:{8'd0, 8'd0, 8'd0, 8'd0}, nb:{8'd8, 8'd8, 8'd8, 8'd8},
               rlo_at:8'd0, rlo_len:8'd0, exp_words:8'd8, exp_skew:1'b0,
               exp_len:1'b0, exp_ovf:1'b0, exp_bw:16'd8, exp_lat:8'sd4};
    tbl[1] = '{dly:{8'd2, 8'd0, 8'd0, 8'd0}, nb:{8'd8, 8'd8, 8'd8, 8'd8},
               rlo_at:8'd0, rlo_len:8'd0, exp_words:8'd8, exp_skew:1'b0,
               exp_len:1'b0, exp_ovf:1'b0, exp_bw:16'd8, exp_lat:8'sd6};
    tbl[2] = '{dly:{8'd3, 8'd2, 8'd1, 8'd0}, nb:{8'd8, 8'd8, 8'd8, 8'd8},
               rlo_at:8'd0, rlo_len:8'd0, exp_words:8'd8, exp_skew:1'b0,
               exp_len:1'b0, exp_ovf:1'b0, exp_bw:16'd8, exp_lat:8'sd7};
    tbl[3] = '{dly:{8'd0, 8'd4, 8'd0, 8'd0}, nb:{8'd8, 8'd8, 8'd8, 8'd8},
               rlo_at:8'd0, rlo_len:8'd0, exp_words:8'd0, exp_skew:1'b1,
               exp_len:1'b0, exp_ovf:1'b0, exp_bw:16'd8, exp_lat:-8'sd1};
    tbl[4] = '{dly:{8'd0, 8'd0, 8'd0, 8'd0}, nb:{8'd16, 8'd16, 8'd16, 8'd16},
               rlo_at:8'd2, rlo_len:8'd10, exp_words:8'd0, exp_skew:1'b0,
               exp_len:1'b0, exp_ovf:1'b1, exp_bw:16'd8, exp_lat:8'sd4};
    tbl[5] = '{dly:{8'd0, 8'd0, 8'd0, 8'd0}, nb:{8'd4, 8'd4, 8'd4, 8'd4},
               rlo_at:8'd0, rlo_len:8'd0, exp_words:8'd4, exp_skew:1'b0,
               exp_len:1'b0, exp_ovf:1'b0, exp_bw:16'd4, exp_lat:8'sd4};
    tbl[6] = '{dly:{8'd0, 8'd0, 8'd0, 8'd0}, nb:{8'd8, 8'd8, 8'd7, 8'd8},
               rlo_at:8'd0, rlo_len:8'd0, exp_words:8'd7, exp_skew:1'b0,
               exp_len:1'b1, exp_ovf:1'b0, exp_bw:16'd7, exp_lat:8'sd4};
    tbl[7] = '{dly:{8'd0, 8'd0, 8'd0, 8'd0}, nb:{8'd1, 8'd1, 8'd1, 8'd1},
               rlo_at:8'd0, rlo_len:8'd0, exp_words:8'd1, exp_skew:1'b0,
               exp_len:1'b0, exp_ovf:1'b0, exp_bw:16'd1, exp_lat:8'sd5};

    rst          = 1'b1;
    rx_active_hs = '0;
    rx_sync_hs   = '0;
    rx_valid_hs  = '0;
    rx_data_hs   = '0;
    stop_state   = '1;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 0, out_valid, 1'b0);
    chk("rst_data", 0, out_data, 32'h0);
    chk("rst_sos_eos", 0, {out_sos, out_eos}, 2'b00);
    chk("rst_errs", 0, {err_skew, err_len, err_overflow}, 3'b000);
    chk("rst_all_stop", 0, all_stop, 1'b0);
    chk("rst_bw", 0, burst_words, 16'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    stop_state = 4'b1011;
    @(negedge clk);
    chk("all_stop_hi", 0, all_stop, 1'b1);
    @(posedge clk); #1;
    stop_state = 4'b1111;
    @(negedge clk);
    chk("all_stop_lo", 0, all_stop, 1'b0);

    for (int t = 0; t < 8; t++) run_burst(t, tbl[t]);

    for (int c = 0; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 0) clear_mon();
      drive_cycle(tbl[0], c);
      rst = (c == 6);
      @(negedge clk);
      if (c == 6) chk("pre_rst_valid", 0, out_valid, 1'b1);
      if (c == 7) begin
        chk("post_rst_valid", 0, out_valid, 1'b0);
        chk("post_rst_data", 0, out_data, 32'h0);
        chk("post_rst_bw", 0, burst_words, 16'h0);
        wq.delete();
      end
    end
    chk("post_rst_words", 0, wq.size(), 0);
    run_burst(8, tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
